// File: rtl/bcd_updown_counter_pkg.sv
// rtl/bcd_updown_counter_pkg.sv - shared constants and types for the BCD up/down counter
// Contents: default count-step divider, the 4-bit BCD digit type, and the
// active-low {g,f,e,d,c,b,a} seven-segment patterns for digits 0..9 plus blank.
package counter_pkg;

    // clk cycles per count step: 1 Hz from a 50 MHz clock
    localparam int TICK_DIV_DEFAULT = 50_000_000;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_updown_counter_if.sv
// rtl/bcd_updown_counter_if.sv - control and display bundle of the BCD up/down counter
// Signals:
//   up, pause          : direction / freeze requests from the key-control FSM
//   bcd                : four BCD digits, bcd[3] thousands .. bcd[0] units
//   tick               : one-cycle pulse in the cycle the count steps
//   hex0..hex3         : active-low segment patterns, hex0 = units digit
// master drives up/pause; slave is the counter itself.
interface bcd_updown_counter_if;
    import counter_pkg::*;

    logic             up;
    logic             pause;
    bcd_digit_t [3:0] bcd;
    logic             tick;
    logic [6:0]       hex0;
    logic [6:0]       hex1;
    logic [6:0]       hex2;
    logic [6:0]       hex3;

    modport master (
        output up, pause,
        input  bcd, tick, hex0, hex1, hex2, hex3
    );

    modport slave (
        input  up, pause,
        output bcd, tick, hex0, hex1, hex2, hex3
    );

endinterface

// File: rtl/bcd_updown_counter_seg7_decoder.sv
// rtl/bcd_updown_counter_seg7_decoder.sv - combinational BCD digit to seven-segment decoder
// Ports:
//   digit : 4-bit BCD digit in
//   seg   : active-low {g,f,e,d,c,b,a}; codes 10..15 blank the display
module seg7_decoder
    import counter_pkg::*;
(
    input  bcd_digit_t digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - four-digit BCD up/down counter stepped by a prescaler
// Ports:
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset (prescaler, count and tick cleared)
//   bus     : slave side of bcd_updown_counter_if (up, pause in; bcd, tick, hex0..hex3 out)
// Parameter TICK_DIV (>= 2): clk cycles per count step.
module bcd_updown_counter
    import counter_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
)
(
    input  logic                clk,
    input  logic                reset_n,
    bcd_updown_counter_if.slave bus
);

    localparam int            PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

    logic [PW-1:0]    presc;
    logic             step_en;
    logic             chain;
    logic             tick_q;
    bcd_digit_t [3:0] cnt;
    bcd_digit_t [3:0] cnt_next;

    // Terminal prescaler value is the count enable; pause holds it at TERM so
    // the suppressed step fires on the first unpaused edge.
    assign step_en = !bus.pause && (presc == TERM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (!bus.pause) begin
            presc <= step_en ? '0 : presc + 1'b1;
        end
    end

    // Ripple the carry/borrow from the units digit upward; the chain stops at
    // the first digit that does not wrap, so 9999 <-> 0000 is a single step.
    always_comb begin
        cnt_next = cnt;
        chain    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (chain) begin
                if (bus.up) begin
                    if (cnt[i] >= 4'd9) begin
                        cnt_next[i] = 4'd0;
                    end else begin
                        cnt_next[i] = cnt[i] + 4'd1;
                        chain       = 1'b0;
                    end
                end else begin
                    if (cnt[i] == 4'd0) begin
                        cnt_next[i] = 4'd9;
                    end else begin
                        cnt_next[i] = cnt[i] - 4'd1;
                        chain       = 1'b0;
                    end
                end
            end
        end
    end

    // tick is registered from the same enable that loads the count, so it is
    // high exactly in the cycle bcd first shows the new value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= step_en;
            if (step_en) begin
                cnt <= cnt_next;
            end
        end
    end

    assign bus.bcd  = cnt;
    assign bus.tick = tick_q;

    seg7_decoder u_seg0 (.digit(cnt[0]), .seg(bus.hex0));
    seg7_decoder u_seg1 (.digit(cnt[1]), .seg(bus.hex1));
    seg7_decoder u_seg2 (.digit(cnt[2]), .seg(bus.hex2));
    seg7_decoder u_seg3 (.digit(cnt[3]), .seg(bus.hex3));

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - self-checking bench for bcd_updown_counter (TICK_DIV = 4)
module tb_bcd_updown_counter;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    bcd_updown_counter_if u_if ();

    bcd_updown_counter #(.TICK_DIV(DIV)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    typedef struct {
        logic        up;
        int          cycles;
        logic [15:0] exp_bcd;
        int          exp_ticks;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] bcd_of(input int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic chk_hex(input string nm, input int n);
        chk({nm, "_hex0"}, 32'(u_if.hex0), 32'(seg_tab[n % 10]));
        chk({nm, "_hex1"}, 32'(u_if.hex1), 32'(seg_tab[(n / 10) % 10]));
        chk({nm, "_hex2"}, 32'(u_if.hex2), 32'(seg_tab[(n / 100) % 10]));
        chk({nm, "_hex3"}, 32'(u_if.hex3), 32'(seg_tab[n / 1000]));
    endtask

    // Called #1 after a rising edge; reset is checked before any further edge.
    task automatic apply_reset(input string nm);
        u_if.pause = 1'b0;
        reset_n = 1'b0;
        #1;
        chk({nm, "_bcd"}, 32'(u_if.bcd), 32'h0);
        chk({nm, "_tick"}, 32'(u_if.tick), 32'h0);
        chk_hex(nm, 0);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic run_cycles(input int n, output int ticks);
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (u_if.tick === 1'b1) ticks++;
        end
    endtask

    int ticks;
    int m_cnt;
    int m_pre;
    int m_tick;

    initial begin
        u_if.up    = 1'b1;
        u_if.pause = 1'b0;

        vecs[0] = '{1'b1, 40, 16'h0010, 10};
        vecs[1] = '{1'b0,  4, 16'h9999,  1};
        vecs[2] = '{1'b0,  8, 16'h9998,  2};
        vecs[3] = '{1'b1,  3, 16'h0000,  0};
        vecs[4] = '{1'b1,  4, 16'h0001,  1};
        vecs[5] = '{1'b0, 44, 16'h9989, 11};
        vecs[6] = '{1'b1,  7, 16'h0001,  1};

        @(posedge clk);
        #1;
        chk("por_bcd", 32'(u_if.bcd), 32'h0);
        chk("por_tick", 32'(u_if.tick), 32'h0);
        chk_hex("por", 0);
        reset_n = 1'b1;

        // Table: each row starts from reset and counts in one direction.
        for (int v = 0; v < 7; v++) begin
            apply_reset($sformatf("vec%0d_rst", v));
            u_if.up = vecs[v].up;
            run_cycles(vecs[v].cycles, ticks);
            chk($sformatf("vec%0d_bcd", v), 32'(u_if.bcd), 32'(vecs[v].exp_bcd));
            chk($sformatf("vec%0d_ticks", v), 32'(ticks), 32'(vecs[v].exp_ticks));
        end

        // 0999 -> 1000 in one step
        apply_reset("carry_rst");
        u_if.up = 1'b1;
        run_cycles(999 * DIV + DIV - 1, ticks);
        chk("carry_pre_bcd", 32'(u_if.bcd), 32'h0999);
        chk("carry_pre_tick", 32'(u_if.tick), 32'h0);
        run_cycles(1, ticks);
        chk("carry_bcd", 32'(u_if.bcd), 32'h1000);
        chk("carry_tick", 32'(u_if.tick), 32'h1);
        chk("carry_hex3", 32'(u_if.hex3), 32'b1111001);
        chk("carry_hex2", 32'(u_if.hex2), 32'b1000000);
        chk("carry_hex1", 32'(u_if.hex1), 32'b1000000);
        chk("carry_hex0", 32'(u_if.hex0), 32'b1000000);
        run_cycles(1, ticks);
        chk("carry_tick_width", 32'(u_if.tick), 32'h0);

        // Pause at prescaler = 3 for 10 cycles
        apply_reset("pause_rst");
        u_if.up = 1'b1;
        run_cycles(3, ticks);
        u_if.pause = 1'b1;
        run_cycles(10, ticks);
        chk("pause_bcd", 32'(u_if.bcd), 32'h0);
        chk("pause_ticks", 32'(ticks), 32'h0);
        u_if.pause = 1'b0;
        run_cycles(1, ticks);
        chk("pause_rel_bcd", 32'(u_if.bcd), 32'h0001);
        chk("pause_rel_tick", 32'(u_if.tick), 32'h1);

        // Direction change mid-period does not restart the prescaler
        apply_reset("dir_rst");
        u_if.up = 1'b1;
        run_cycles(5 * DIV + 2, ticks);
        chk("dir_pre_bcd", 32'(u_if.bcd), 32'h0005);
        u_if.up = 1'b0;
        run_cycles(1, ticks);
        chk("dir_mid_bcd", 32'(u_if.bcd), 32'h0005);
        chk("dir_mid_tick", 32'(u_if.tick), 32'h0);
        run_cycles(1, ticks);
        chk("dir_bcd", 32'(u_if.bcd), 32'h0004);
        chk("dir_tick", 32'(u_if.tick), 32'h1);

        // Asynchronous reset mid-period at 0042, then restart timing
        apply_reset("mid_rst0");
        u_if.up = 1'b1;
        run_cycles(42 * DIV + 2, ticks);
        chk("mid_pre_bcd", 32'(u_if.bcd), 32'h0042);
        apply_reset("mid_rst");
        run_cycles(DIV - 1, ticks);
        chk("mid_wait_bcd", 32'(u_if.bcd), 32'h0);
        chk("mid_wait_ticks", 32'(ticks), 32'h0);
        run_cycles(1, ticks);
        chk("mid_first_bcd", 32'(u_if.bcd), 32'h0001);
        chk("mid_first_tick", 32'(u_if.tick), 32'h1);

        // Random up/pause/reset against an integer reference model
        apply_reset("rnd_rst");
        m_cnt = 0;
        m_pre = 0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 249) == 0) begin
                apply_reset("rnd_mid_rst");
                m_cnt = 0;
                m_pre = 0;
                continue;
            end
            u_if.up    = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
            u_if.pause = ($urandom_range(0, 3) == 0);
            m_tick = 0;
            if (!u_if.pause) begin
                if (m_pre == DIV - 1) begin
                    m_pre  = 0;
                    m_tick = 1;
                    m_cnt  = u_if.up ? (m_cnt + 1) % 10000 : (m_cnt + 9999) % 10000;
                end else begin
                    m_pre++;
                end
            end
            @(posedge clk);
            #1;
            chk("rnd_bcd", 32'(u_if.bcd), 32'(bcd_of(m_cnt)));
            chk("rnd_tick", 32'(u_if.tick), 32'(m_tick));
            chk_hex("rnd", m_cnt);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
